// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_DATA_W = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Final result correction: restores signs on the magnitude result and
// substitutes the fixed divide-by-zero pattern.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  mdu_op_e             op,
    input  logic [DATA_W-1:0]   raw_hi,
    input  logic [DATA_W-1:0]   raw_lo,
    input  logic [DATA_W-1:0]   dividend,
    input  logic                neg_res,
    input  logic                neg_rem,
    input  logic                div_zero,
    output logic [DATA_W-1:0]   fix_hi,
    output logic [DATA_W-1:0]   fix_lo
);

    logic [2*DATA_W-1:0] prod_neg;

    assign prod_neg = -{raw_hi, raw_lo};

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        fix_hi = raw_hi;
        fix_lo = raw_lo;
        if (div_zero) begin
            fix_hi = dividend;
            fix_lo = '1;
        end else if (op_is_div(op)) begin
            if (neg_res) fix_lo = -raw_lo;
            if (neg_rem) fix_hi = -raw_hi;
        end else if (neg_res) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle shift-add multiplier / restoring divider holding HI/LO.
// Works on operand magnitudes; signs are restored in the FIX cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [1:0]          op_i,
    input  logic [DATA_W-1:0]   rs_data_i,
    input  logic [DATA_W-1:0]   rt_data_i,
    input  logic                cancel_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                div_zero_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mdu_state_e          state;
    mdu_op_e             op_q;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   a_mag, b_mag, rs_q;
    logic                neg_res, neg_rem, dz_q;
    logic [2*DATA_W-1:0] prod, prod_next;

    mdu_op_e             op_in;
    logic                sgn_in, rs_neg, rt_neg;
    logic [DATA_W-1:0]   rs_mag, rt_mag;
    logic [DATA_W:0]     add_sum, rem_sh, diff;
    logic [DATA_W-1:0]   fix_hi, fix_lo;

    assign op_in  = mdu_op_e'(op_i);
    assign sgn_in = op_is_signed(op_in);
    assign rs_neg = sgn_in & rs_data_i[DATA_W-1];
    assign rt_neg = sgn_in & rt_data_i[DATA_W-1];
    assign rs_mag = rs_neg ? -rs_data_i : rs_data_i;
    assign rt_mag = rt_neg ? -rt_data_i : rt_data_i;

    // Multiply: {prod_hi, multiplier} shifts right. Divide: {remainder, quotient} shifts left.
    always_comb begin
        add_sum = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, a_mag} : '0);
        rem_sh  = {prod[2*DATA_W-1:DATA_W], prod[DATA_W-1]};
        diff    = rem_sh - {1'b0, b_mag};
        if (!op_is_div(op_q)) begin
            prod_next = {add_sum, prod[DATA_W-1:1]};
        end else if (!diff[DATA_W]) begin
            prod_next = {diff[DATA_W-1:0], prod[DATA_W-2:0], 1'b1};
        end else begin
            prod_next = {rem_sh[DATA_W-1:0], prod[DATA_W-2:0], 1'b0};
        end
    end

    mdu_sign_fix #(.DATA_W(DATA_W)) u_sign_fix (
        .op       (op_q),
        .raw_hi   (prod[2*DATA_W-1:DATA_W]),
        .raw_lo   (prod[DATA_W-1:0]),
        .dividend (rs_q),
        .neg_res  (neg_res),
        .neg_rem  (neg_rem),
        .div_zero (dz_q),
        .fix_hi   (fix_hi),
        .fix_lo   (fix_lo)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            op_q       <= MDU_MULT;
            count      <= '0;
            a_mag      <= '0;
            b_mag      <= '0;
            rs_q       <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            dz_q       <= 1'b0;
            prod       <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !cancel_i) begin
                        state      <= RUN;
                        busy_o     <= 1'b1;
                        div_zero_o <= 1'b0;
                        count      <= '0;
                        op_q       <= op_in;
                        a_mag      <= rs_mag;
                        b_mag      <= rt_mag;
                        rs_q       <= rs_data_i;
                        neg_res    <= rs_neg ^ rt_neg;
                        neg_rem    <= rs_neg & op_is_div(op_in);
                        dz_q       <= op_is_div(op_in) && (rt_data_i == '0);
                        prod       <= op_is_div(op_in) ? {{DATA_W{1'b0}}, rs_mag}
                                                       : {{DATA_W{1'b0}}, rt_mag};
                    end
                end
                RUN: begin
                    if (cancel_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        prod  <= prod_next;
                        count <= count + 1'b1;
                        if (count == CNT_LAST) state <= FIX;
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (!cancel_i) begin
                        hi_o       <= fix_hi;
                        lo_o       <= fix_lo;
                        done_o     <= 1'b1;
                        div_zero_o <= dz_q;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic, latency, and
// the busy/cancel/reset/divide-by-zero corner cases.
module tb_mul_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_data_i, rt_data_i;
    logic        cancel_i;
    logic        busy_o, done_o, div_zero_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;
    int edges, busy_cnt, done_cnt;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    mul_div_unit dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs_data_i  (rs_data_i),
        .rt_data_i  (rt_data_i),
        .cancel_i   (cancel_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        op_i      = op;
        rs_data_i = a;
        rt_data_i = b;
        start_i   = 1'b1;
        step();
        start_i   = 1'b0;
    endtask

    // Called right after the accept edge; counts edges until done_o, bounded.
    task automatic wait_done();
        edges    = 0;
        busy_cnt = busy_o ? 1 : 0;
        while (!done_o && edges < 40) begin
            step();
            edges++;
            if (busy_o) busy_cnt++;
        end
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
        op_i = OP_MULT; rs_data_i = '0; rt_data_i = '0;
        step(); step();
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done_dz", {62'd0, done_o, div_zero_o}, 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        rst_i = 1'b1;
        step();

        // 1: MULTU max*max
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        check("multu_latency", 64'(edges), 64'd33);
        check("multu_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
        step();
        check("done_one_cycle", 64'(done_o), 64'd0);

        // 2: MULT -7*3
        start_op(OP_MULT, 32'hFFFF_FFF9, 32'd3);
        wait_done();
        check("mult_busy_cycles", 64'(busy_cnt), 64'd33);
        check("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);

        // 3: divides
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        check("div_neg7_2", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_done();
        check("divu_100_7", {hi_o, lo_o}, {32'd2, 32'd14});
        start_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done();
        check("div_7_neg2", {hi_o, lo_o}, {32'd1, 32'hFFFF_FFFD});
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        check("div_overflow", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
        check("div_overflow_dz", 64'(div_zero_o), 64'd0);

        // 4: divide by zero, then flag clears on next accept
        start_op(OP_DIVU, 32'd5, 32'd0);
        wait_done();
        check("divz_latency", 64'(edges), 64'd33);
        check("divz_hilo", {hi_o, lo_o}, {32'd5, 32'hFFFF_FFFF});
        check("divz_flag", 64'(div_zero_o), 64'd1);
        start_op(OP_MULT, 32'd6, 32'd7);
        check("divz_clear_on_accept", 64'(div_zero_o), 64'd0);
        check("hilo_stable_in_run", {hi_o, lo_o}, {32'd5, 32'hFFFF_FFFF});
        wait_done();
        check("mult_6_7", {hi_o, lo_o}, 64'd42);

        // 5a: start while busy is ignored
        start_op(OP_MULT, 32'd3, 32'd5);
        repeat (4) step();
        op_i = OP_MULTU; rs_data_i = 32'd9; rt_data_i = 32'd9; start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_done();
        check("busy_start_latency", 64'(edges), 64'd28);
        check("busy_start_ignored", {hi_o, lo_o}, 64'd15);
        step();
        check("busy_start_no_requeue", 64'(busy_o), 64'd0);

        // 5b: cancel mid-run
        start_op(OP_MULT, 32'd11, 32'd13);
        repeat (8) step();
        cancel_i = 1'b1;
        step();
        cancel_i = 1'b0;
        check("cancel_busy", 64'(busy_o), 64'd0);
        done_cnt = 0;
        repeat (40) begin
            step();
            if (done_o) done_cnt++;
        end
        check("cancel_no_done", 64'(done_cnt), 64'd0);
        check("cancel_hilo_kept", {hi_o, lo_o}, 64'd15);

        // cancel beats start in IDLE
        op_i = OP_MULT; rs_data_i = 32'd2; rt_data_i = 32'd2;
        start_i = 1'b1; cancel_i = 1'b1;
        step();
        start_i = 1'b0; cancel_i = 1'b0;
        check("cancel_prio_busy", 64'(busy_o), 64'd0);

        // 6: reset mid-DIV, then a clean DIV
        start_op(OP_DIV, 32'd100, 32'hFFFF_FFF9);
        repeat (19) step();
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        check("midrst_flags", {61'd0, busy_o, done_o, div_zero_o}, 64'd0);
        check("midrst_hilo", {hi_o, lo_o}, 64'd0);
        start_op(OP_DIV, 32'd100, 32'hFFFF_FFF9);
        wait_done();
        check("post_rst_latency", 64'(edges), 64'd33);
        check("post_rst_div", {hi_o, lo_o}, {32'd2, 32'hFFFF_FFF2});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
